// File: rtl/fb_imm_pkg.sv
// fb_imm_pkg: format codes and opcode constants shared by the
// immediate-generation unit and its decoder.
package fb_imm_pkg;

  localparam int FMT_W = 3;

  typedef enum logic [FMT_W-1:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

endpackage

// File: rtl/fb_imm_decode.sv
// fb_imm_decode: combinational format decode + immediate build.
// in: inst[31:0]; out: imm[XLEN-1:0], fmt, illegal (FB_IMM_ILLEGAL_EN).
module fb_imm_decode
  import fb_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt
`ifdef FB_IMM_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  localparam bit RV64 = (XLEN == 64);

  logic [31:0] imm32;

  always_comb begin
    fmt = FMT_NONE;
    case (inst[6:0])
      OP_LOAD,
      OP_IMM,
      OP_JALR,
      OP_SYSTEM: fmt = FMT_I;
      OP_IMM32:  fmt = RV64 ? FMT_I : FMT_NONE;
      OP_STORE:  fmt = FMT_S;
      OP_BRANCH: fmt = FMT_B;
      OP_LUI,
      OP_AUIPC:  fmt = FMT_U;
      OP_JAL:    fmt = FMT_J;
      OP_OP:     fmt = FMT_R;
      OP_OP32:   fmt = RV64 ? FMT_R : FMT_NONE;
      default:   fmt = FMT_NONE;
    endcase
  end

  // All formats fit in 32 bits; widen once with sign.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S: imm32 = {{20{inst[31]}}, inst[31:25],
                      inst[11:7]};
      FMT_B: imm32 = {{19{inst[31]}}, inst[31], inst[7],
                      inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm32 = {inst[31:12], 12'b0};
      FMT_J: imm32 = {{11{inst[31]}}, inst[31],
                      inst[19:12], inst[20],
                      inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

`ifdef FB_IMM_ILLEGAL_EN
  assign illegal = (fmt == FMT_NONE)
                 || (inst[1:0] != 2'b11);
`endif

endmodule

// File: rtl/fb_imm_unit.sv
// fb_imm_unit: immediate decode followed by a 2-entry skid buffer.
// Optional out_illegal port when FB_IMM_ILLEGAL_EN is defined.
module fb_imm_unit
  import fb_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag
`ifdef FB_IMM_ILLEGAL_EN
  ,
  output logic             out_illegal
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic [TAG_W-1:0] tag;
`ifdef FB_IMM_ILLEGAL_EN
    logic             ill;
`endif
  } beat_t;

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
`ifdef FB_IMM_ILLEGAL_EN
  logic            dec_ill;
`endif

  fb_imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .inst(in_inst),
    .imm (dec_imm),
    .fmt (dec_fmt)
`ifdef FB_IMM_ILLEGAL_EN
    ,
    .illegal(dec_ill)
`endif
  );

  beat_t in_beat;
  beat_t main_q;
  beat_t skid_q;
  logic  main_v;
  logic  skid_v;
  logic  ready_q;

  always_comb begin
    in_beat     = '0;
    in_beat.imm = dec_imm;
    in_beat.fmt = dec_fmt;
    in_beat.tag = in_tag;
`ifdef FB_IMM_ILLEGAL_EN
    in_beat.ill = dec_ill;
`endif
  end

  logic accept;
  logic load;

  assign accept = in_valid & ready_q;
  // Main entry may take new data when empty or leaving.
  assign load   = ~main_v | out_ready;

  // ready_q mirrors ~skid_v, so a full skid never sees accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v     <= 1'b0;
      skid_v     <= 1'b0;
      ready_q    <= 1'b1;
      main_q     <= '0;
      main_q.fmt <= FMT_NONE;
      skid_q     <= '0;
      skid_q.fmt <= FMT_NONE;
    end else if (flush) begin
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      ready_q <= 1'b1;
    end else if (load) begin
      if (skid_v) begin
        main_q  <= skid_q;
        main_v  <= 1'b1;
        skid_v  <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        main_v <= accept;
        if (accept) main_q <= in_beat;
      end
    end else if (accept) begin
      skid_q  <= in_beat;
      skid_v  <= 1'b1;
      ready_q <= 1'b0;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_v;
  assign out_imm   = main_q.imm;
  assign out_type  = main_q.fmt;
  assign out_tag   = main_q.tag;
`ifdef FB_IMM_ILLEGAL_EN
  assign out_illegal = main_q.ill;
`endif

endmodule

// File: tb/tb_fb_imm_unit.sv
// tb_fb_imm_unit: randomized + directed checks of fb_imm_unit
// (XLEN=32 and XLEN=64 instances driven in parallel).
module tb_fb_imm_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [7:0]  in_tag = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_imm;
  logic [2:0]  out_type;
  logic [7:0]  out_tag;
  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64;
  logic [2:0]  out_type64;
  logic [7:0]  out_tag64;
`ifdef FB_IMM_ILLEGAL_EN
  logic        out_illegal, out_illegal64;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fb_imm_unit #(.XLEN(32), .TAG_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_type(out_type),
    .out_tag(out_tag)
`ifdef FB_IMM_ILLEGAL_EN
    , .out_illegal(out_illegal)
`endif
  );

  fb_imm_unit #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_type(out_type64),
    .out_tag(out_tag64)
`ifdef FB_IMM_ILLEGAL_EN
    , .out_illegal(out_illegal64)
`endif
  );

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  t32;
    logic [2:0]  t64;
    logic [7:0]  tag;
    logic        ill32;
    logic        ill64;
  } exp_t;

  exp_t q[$];

  // Reference: type from opcode table, immediate as signed offset sum.
  function automatic void ref_model(input logic [31:0] i,
                                    input bit x64,
                                    output logic [63:0] imm,
                                    output logic [2:0] t);
    longint v;
    longint s;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: t = 3'd1;
      7'h1B: t = x64 ? 3'd1 : 3'd7;
      7'h23: t = 3'd2;
      7'h63: t = 3'd3;
      7'h37, 7'h17: t = 3'd4;
      7'h6F: t = 3'd5;
      7'h33: t = 3'd0;
      7'h3B: t = x64 ? 3'd0 : 3'd7;
      default: t = 3'd7;
    endcase
    s = i[31] ? 64'd1 : 64'd0;
    case (t)
      3'd1: v = longint'(i[31:20]) - s * 4096;
      3'd2: v = longint'({i[31:25], i[11:7]}) - s * 4096;
      3'd3: v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
              + longint'(i[11:8]) * 2 - s * 4096;
      3'd4: v = longint'(i[31:12]) * 4096 - s * (longint'(1) << 32);
      3'd5: v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
              + longint'(i[30:21]) * 2 - s * (longint'(1) << 20);
      default: v = 0;
    endcase
    imm = v;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] i,
                                  input logic [7:0] tg);
    exp_t e;
    logic [63:0] a;
    ref_model(i, 1'b0, a, e.t32);
    e.imm32 = a[31:0];
    ref_model(i, 1'b1, e.imm64, e.t64);
    e.tag = tg;
    e.ill32 = (e.t32 == 3'd7) || (i[1:0] != 2'b11);
    e.ill64 = (e.t64 == 3'd7) || (i[1:0] != 2'b11);
    return e;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if ({out_valid, in_ready, out_imm, out_type, out_tag} !==
        {1'b0, 1'b1, 32'h0, 3'd7, 8'h0}) begin
      $display("FAIL reset32 got v=%b r=%b imm=%h t=%0d tag=%h want v=0 r=1 imm=0 t=7 tag=0",
               out_valid, in_ready, out_imm, out_type, out_tag);
    end else n_pass++;
    n_total++;
    if ({out_valid64, in_ready64, out_imm64, out_type64} !==
        {1'b0, 1'b1, 64'h0, 3'd7}) begin
      $display("FAIL reset64 got v=%b r=%b imm=%h t=%0d want v=0 r=1 imm=0 t=7",
               out_valid64, in_ready64, out_imm64, out_type64);
    end else n_pass++;
`ifdef FB_IMM_ILLEGAL_EN
    n_total++;
    if (out_illegal !== 1'b0) begin
      $display("FAIL reset_illegal got %b want 0", out_illegal);
    end else n_pass++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] ins[6];
    logic [31:0] imms[6];
    logic [2:0]  tys[6];
    ins  = '{32'hFFF00093, 32'hFE20AE23, 32'h00000463,
             32'h12345037, 32'h0080006F, 32'h800000B7};
    imms = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008,
             32'h12345000, 32'h00000008, 32'h80000000};
    tys  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4};
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_inst = ins[k];
      in_tag = 8'h10 + 8'(k);
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_total++;
      if ({out_valid, out_imm, out_type, out_tag} !==
          {1'b1, imms[k], tys[k], 8'h10 + 8'(k)}) begin
        $display("FAIL directed%0d got v=%b imm=%h t=%0d tag=%h want v=1 imm=%h t=%0d tag=%h",
                 k, out_valid, out_imm, out_type, out_tag,
                 imms[k], tys[k], 8'h10 + 8'(k));
      end else n_pass++;
    end
    n_total++;
    if (out_imm64 !== 64'hFFFFFFFF80000000 || out_type64 !== 3'd4) begin
      $display("FAIL lui64 got imm=%h t=%0d want imm=ffffffff80000000 t=4",
               out_imm64, out_type64);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL directed_drain got v=%b want 0", out_valid);
    end else n_pass++;
  endtask

`ifdef FB_IMM_ILLEGAL_EN
  task automatic test_illegal();
    in_valid = 1'b1;
    in_inst = 32'h0000007F;
    in_tag = 8'h77;
    out_ready = 1'b1;
    @(negedge clk);
    in_inst = 32'h00000093;
    n_total++;
    if ({out_illegal, out_type, out_imm} !== {1'b1, 3'd7, 32'h0}) begin
      $display("FAIL illegal got ill=%b t=%0d imm=%h want ill=1 t=7 imm=0",
               out_illegal, out_type, out_imm);
    end else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_total++;
    if ({out_illegal, out_type} !== {1'b0, 3'd1}) begin
      $display("FAIL legal got ill=%b t=%0d want ill=0 t=1",
               out_illegal, out_type);
    end else n_pass++;
    @(negedge clk);
  endtask
`endif

  task automatic test_backpressure();
    int nxt = 1;
    bit acc;
    logic [7:0] got[$];
    out_ready = 1'b0;
    repeat (4) begin
      in_valid = 1'b1;
      in_inst = 32'h00000013;
      in_tag = 8'(nxt);
      acc = in_ready;
      @(negedge clk);
      if (acc) nxt++;
    end
    n_total++;
    if (nxt - 1 != 2 || in_ready !== 1'b0 || out_tag !== 8'd1) begin
      $display("FAIL bp_stall got acc=%0d rdy=%b tag=%h want acc=2 rdy=0 tag=01",
               nxt - 1, in_ready, out_tag);
    end else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      in_valid = (nxt <= 3);
      in_tag = 8'(nxt);
      acc = in_valid && in_ready;
      if (out_valid) got.push_back(out_tag);
      @(negedge clk);
      if (acc) nxt++;
    end
    in_valid = 1'b0;
    n_total++;
    if (got.size() != 3) begin
      $display("FAIL bp_count got %0d beats want 3", got.size());
    end else begin
      if (got[0] !== 8'd1 || got[1] !== 8'd2 || got[2] !== 8'd3) begin
        $display("FAIL bp_order got %h %h %h want 01 02 03",
                 got[0], got[1], got[2]);
      end else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL bp_drain got v=%b want 0", out_valid);
    end else n_pass++;
  endtask

  task automatic test_flush();
    bit seen;
    out_ready = 1'b0;
    in_inst = 32'h00000013;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_tag = 8'hA1 + 8'(k);
      @(negedge clk);
    end
    n_total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      $display("FAIL flush_fill got rdy=%b v=%b want rdy=0 v=1",
               in_ready, out_valid);
    end else n_pass++;
    flush = 1'b1;
    in_tag = 8'hA3;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL flush_full got v=%b rdy=%b want v=0 rdy=1",
               out_valid, in_ready);
    end else n_pass++;
    in_valid = 1'b1;
    in_tag = 8'hA4;
    @(negedge clk);
    flush = 1'b1;
    in_tag = 8'hA5;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = (out_valid !== 1'b0) || (in_ready !== 1'b1);
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_total++;
    if (seen) begin
      $display("FAIL flush_discard got stale beat tag=%h want none",
               out_tag);
    end else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0] ops[14];
    logic [31:0] r;
    logic [31:0] ins;
    bit acc, xfer;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h00};
    q.delete();
    for (int c = 0; c < 400; c++) begin
      n_total++;
      if (out_valid !== (q.size() != 0) ||
          out_valid64 !== (q.size() != 0) ||
          in_ready !== (q.size() < 2) ||
          in_ready64 !== (q.size() < 2)) begin
        $display("FAIL rnd_hs c=%0d got v=%b/%b r=%b/%b want occ=%0d",
                 c, out_valid, out_valid64, in_ready, in_ready64,
                 q.size());
      end else n_pass++;
      if (q.size() != 0) begin
        n_total++;
        if ({out_imm, out_type, out_tag} !==
            {q[0].imm32, q[0].t32, q[0].tag}) begin
          $display("FAIL rnd_out32 c=%0d got imm=%h t=%0d tag=%h want imm=%h t=%0d tag=%h",
                   c, out_imm, out_type, out_tag,
                   q[0].imm32, q[0].t32, q[0].tag);
        end else n_pass++;
        n_total++;
        if ({out_imm64, out_type64, out_tag64} !==
            {q[0].imm64, q[0].t64, q[0].tag}) begin
          $display("FAIL rnd_out64 c=%0d got imm=%h t=%0d tag=%h want imm=%h t=%0d tag=%h",
                   c, out_imm64, out_type64, out_tag64,
                   q[0].imm64, q[0].t64, q[0].tag);
        end else n_pass++;
`ifdef FB_IMM_ILLEGAL_EN
        n_total++;
        if ({out_illegal, out_illegal64} !== {q[0].ill32, q[0].ill64}) begin
          $display("FAIL rnd_ill c=%0d got %b%b want %b%b",
                   c, out_illegal, out_illegal64, q[0].ill32, q[0].ill64);
        end else n_pass++;
`endif
      end
      r = $urandom();
      ins = {r[31:7], ops[$urandom_range(0, 13)]};
      if ($urandom_range(0, 7) == 0) ins[6:0] = r[6:0];
      in_inst = ins;
      in_tag = 8'($urandom());
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      acc = in_valid && (q.size() < 2);
      xfer = out_ready && (q.size() != 0);
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back(mk_exp(in_inst, in_tag));
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL rnd_drain got v=%b want 0", out_valid);
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_inst = 32'h00000013;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_tag = 8'hC1 + 8'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, out_valid64, in_ready, out_tag, out_type} !==
        {1'b0, 1'b0, 1'b1, 8'h0, 3'd7}) begin
      $display("FAIL reset_async got v=%b/%b r=%b tag=%h t=%0d want v=0/0 r=1 tag=0 t=7",
               out_valid, out_valid64, in_ready, out_tag, out_type);
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL reset_release got r=%b v=%b want r=1 v=0",
               in_ready, out_valid);
    end else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
`ifdef FB_IMM_ILLEGAL_EN
    test_illegal();
`endif
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
